// File: rtl/bootrom_pkg.sv
// bootrom_pkg: shared FSM state type, wait-counter width and the default boot image.
package bootrom_pkg;
    typedef enum logic [1:0] {LOAD, RUN, RD_WAIT, RD_HOLD} state_e;
    localparam int WCNT_W = 3;
    localparam int IMG_LEN = 10;
    localparam logic [7:0] IMG [IMG_LEN] = '{
        8'h21, 8'h00, 8'hD0, 8'h3E, 8'h00, 8'h77, 8'h23, 8'h3C, 8'h18, 8'hFB
    };
endpackage

// File: rtl/bootrom_mem.sv
// bootrom_mem: single-clock image RAM, one write port, one registered read port.
// BOOTROM_INIT_EN preloads the default image; otherwise contents come only from download.
module bootrom_mem
    import bootrom_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
`ifdef BOOTROM_INIT_EN
    initial begin
        for (int i = 0; i < 2**ADDR_W; i++) mem[i] = '0;
        for (int i = 0; i < IMG_LEN; i++) mem[i] = DATA_W'(IMG[i]);
    end
`endif
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/bootrom_ldr.sv
// bootrom_ldr: downloads a boot image into RAM, then serves CPU reads with wait states.
// BOOTROM_INIT_EN starts from the preloaded image in RUN instead of LOAD.
module bootrom_ldr
    import bootrom_pkg::*;
#(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 8,
    parameter int WAIT_CYC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_cs,
    input  logic              cpu_rd,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [DATA_W-1:0] cpu_data,
    output logic              cpu_wait_n,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_done
);
`ifdef BOOTROM_INIT_EN
    localparam state_e RST_ST = RUN;
`else
    localparam state_e RST_ST = LOAD;
`endif
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ld_cnt_q, ld_cnt_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0] cpu_data_q, cpu_data_d, mem_rdata;
    logic              strobe, mem_we, mem_re;

    assign strobe   = cpu_cs & cpu_rd;
    assign cpu_data = cpu_data_q;

    bootrom_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (ld_cnt_q),
        .wdata (ld_data),
        .re    (mem_re),
        .raddr (cpu_addr),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RST_ST;
            ld_cnt_q   <= '0;
            wait_cnt_q <= '0;
            cpu_data_q <= '0;
        end else begin
            state_q    <= state_d;
            ld_cnt_q   <= ld_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            cpu_data_q <= cpu_data_d;
        end
    end

    // With WAIT_CYC=0 a nonzero wait_cnt in RD_HOLD marks the RAM word still to be captured.
    always_comb begin
        state_d    = state_q;
        ld_cnt_d   = ld_cnt_q;
        wait_cnt_d = wait_cnt_q;
        cpu_data_d = cpu_data_q;
        case (state_q)
            LOAD: if (mem_we) begin
                ld_cnt_d = ld_cnt_q + 1'b1;
                if (&ld_cnt_q) state_d = RUN;
            end
            RUN: if (strobe) begin
                state_d    = (WAIT_CYC > 0) ? RD_WAIT : RD_HOLD;
                wait_cnt_d = (WAIT_CYC > 0) ? '0 : WCNT_W'(1);
            end
            RD_WAIT: if (wait_cnt_q == WCNT_W'(WAIT_CYC - 1)) begin
                state_d    = RD_HOLD;
                wait_cnt_d = '0;
                cpu_data_d = mem_rdata;
            end else begin
                wait_cnt_d = wait_cnt_q + WCNT_W'(1);
            end
            RD_HOLD: begin
                if (wait_cnt_q != '0) begin
                    cpu_data_d = mem_rdata;
                    wait_cnt_d = '0;
                end
                if (!strobe) state_d = RUN;
            end
            default: state_d = LOAD;
        endcase
        if (ld_start) begin
            state_d    = LOAD;
            ld_cnt_d   = '0;
            wait_cnt_d = '0;
        end
    end

    always_comb begin
        ld_ready   = (state_q == LOAD) && !ld_start;
        ld_done    = state_q != LOAD;
        mem_we     = ld_ready && ld_valid;
        mem_re     = (state_q == RUN) && strobe && !ld_start;
        cpu_wait_n = !rst_n || ((state_q == RD_WAIT) ? 1'b0 :
                                (state_q == RD_HOLD) ? (wait_cnt_q == '0) : !strobe);
    end
endmodule

// File: tb/tb_bootrom_ldr.sv
// tb_bootrom_ldr: scoreboard bench for bootrom_ldr with WAIT_CYC=3, default build.
module tb_bootrom_ldr;
    logic        clk = 0, rst_n = 0, cpu_cs = 0, cpu_rd = 0, ld_start = 0, ld_valid = 0;
    logic [10:0] cpu_addr = '0;
    logic [7:0]  ld_data = '0, cpu_data;
    logic        cpu_wait_n, ld_ready, ld_done;
    logic [7:0]  mem_m [2048];
    logic [7:0]  exp_q [$];
    logic [7:0]  last_exp = '0;
    int          errs = 0, checks = 0;

    always #5 clk = ~clk;

    bootrom_ldr #(.ADDR_W(11), .DATA_W(8), .WAIT_CYC(3)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_cs(cpu_cs), .cpu_rd(cpu_rd), .cpu_addr(cpu_addr),
        .cpu_data(cpu_data), .cpu_wait_n(cpu_wait_n), .ld_start(ld_start),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready), .ld_done(ld_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int mode, input int i);
        return mode == 0 ? 8'(i) : mode == 1 ? 8'(i * 3 + 1) : mode == 2 ? (8'(i) ^ 8'h5A) : 8'hA5;
    endfunction

    task automatic stream(input int mode, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (i == 0) chk("ld_ready_start", ld_ready, 1);
            if (i == n - 1) chk("done_before_last", ld_done, 0);
            if (i == 1024) chk("wait_in_load", cpu_wait_n, !(cpu_cs & cpu_rd));
            ld_valid = 1;
            ld_data  = pat(mode, i);
            mem_m[i] = pat(mode, i);
        end
        @(posedge clk); #1;
        ld_valid = 0;
        chk("done_after_last", ld_done, n == 2048);
        chk("ready_after_last", ld_ready, n != 2048);
    endtask

    task automatic wait_rd(input string tag);
        int n;
        for (n = 1; n < 20; n++) begin
            @(posedge clk); #1;
            cpu_addr = ~cpu_addr;
            if (cpu_wait_n) break;
        end
        chk({tag, "_wait_len"}, n, 4);
        last_exp = exp_q.pop_front();
        chk({tag, "_data"}, cpu_data, last_exp);
    endtask

    task automatic rd(input logic [10:0] a);
        @(posedge clk); #1;
        cpu_cs = 1; cpu_rd = 1; cpu_addr = a;
        exp_q.push_back(mem_m[a]);
        #1 chk("rd_launch_wait", cpu_wait_n, 0);
        wait_rd("rd");
        repeat (2) @(posedge clk);
        #1 chk("rd_hold_data", cpu_data, last_exp);
        chk("rd_hold_wait", cpu_wait_n, 1);
        cpu_cs = 0; cpu_rd = 0;
        @(posedge clk); #1;
        chk("rd_idle_wait", cpu_wait_n, 1);
        chk("rd_after_data", cpu_data, last_exp);
    endtask

    initial begin
        cpu_cs = 1; cpu_rd = 1;
        #2;
        chk("rst_data", cpu_data, 0);
        chk("rst_wait", cpu_wait_n, 1);
        chk("rst_done", ld_done, 0);
        chk("rst_ready", ld_ready, 1);
        cpu_cs = 0; cpu_rd = 0;
        @(negedge clk) rst_n = 1;

        stream(3, 1024);
        #2 rst_n = 0;
        #1 chk("midrst_done", ld_done, 0);
        chk("midrst_ready", ld_ready, 1);
        chk("midrst_wait", cpu_wait_n, 1);
        @(negedge clk) rst_n = 1;
        stream(0, 2048);
        rd(11'h7FF);
        rd(11'h123);
        rd(11'h000);

        @(posedge clk); #1 ld_start = 1;
        @(posedge clk); #1 ld_start = 0;
        chk("restart_done", ld_done, 0);
        cpu_cs = 1; cpu_rd = 1; cpu_addr = 11'h005;
        #1 chk("load_stall", cpu_wait_n, 0);
        stream(1, 2048);
        chk("load_launch_wait", cpu_wait_n, 0);
        exp_q.push_back(mem_m[5]);
        wait_rd("load_rd");
        cpu_cs = 0; cpu_rd = 0;
        rd(11'h200);

        @(posedge clk); #1;
        cpu_cs = 1; cpu_rd = 1; cpu_addr = 11'h010;
        @(posedge clk); #1;
        chk("abort_rdwait", cpu_wait_n, 0);
        ld_start = 1; ld_valid = 1; ld_data = 8'hEE; cpu_cs = 0; cpu_rd = 0;
        @(posedge clk); #1;
        ld_start = 0; ld_valid = 0;
        #1 chk("abort_wait", cpu_wait_n, 1);
        chk("abort_done", ld_done, 0);
        chk("abort_ready", ld_ready, 1);
        chk("abort_data", cpu_data, last_exp);
        stream(2, 2048);
        rd(11'h000);
        rd(11'h001);
        rd(11'h7FF);
        chk("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/bootrom_ldr.md
BOOTROM_LDR -- requirements
Module: bootrom_ldr

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, meaning the image address width (depth = 2**ADDR_W bytes).
REQ-002 SHALL have parameter DATA_W, default 8, meaning the data width.
REQ-003 SHALL have parameter WAIT_CYC, default 1 (range 0..7), meaning the number of CPU wait cycles inserted per read.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-006 SHALL have port cpu_cs, input, 1 bit: CPU chip select for the image window.
REQ-007 SHALL have port cpu_rd, input, 1 bit: CPU read strobe.
REQ-008 SHALL have port cpu_addr, input, ADDR_W bits: CPU byte address.
REQ-009 SHALL have port cpu_data, output, DATA_W bits: read data, registered.
REQ-010 SHALL have port cpu_wait_n, output, 1 bit: active-low wait request to the CPU.
REQ-011 SHALL have port ld_start, input, 1 bit: a one-cycle pulse that restarts image download.
REQ-012 SHALL have port ld_valid, input, 1 bit: the download byte on ld_data is valid.
REQ-013 SHALL have port ld_data, input, DATA_W bits: download byte.
REQ-014 SHALL have port ld_ready, output, 1 bit: the block accepts a download byte this cycle.
REQ-015 SHALL have port ld_done, output, 1 bit: the image is complete and the CPU may read.

Function
REQ-016 SHALL implement FSM states LOAD, RUN, RD_WAIT and RD_HOLD.
REQ-017 In LOAD: ld_ready=1; each cycle with ld_valid=1 writes ld_data to the location given by load counter ld_cnt, then increments ld_cnt.
REQ-018 Write of the byte at ld_cnt = 2**ADDR_W-1: ld_cnt wraps to 0, and the FSM moves to RUN on the next cycle with ld_done=1.
REQ-019 In LOAD: cpu_wait_n=0 whenever cpu_cs&cpu_rd; the CPU is stalled until download completes.
REQ-020 In RUN: cpu_cs&cpu_rd launches a synchronous read of cpu_addr and sets cpu_wait_n=0 in the same cycle (combinational from strobes).
- WAIT_CYC>0: goes to RD_WAIT.
- WAIT_CYC=0: goes directly to RD_HOLD.
REQ-021 RD_WAIT SHALL count WAIT_CYC cycles, then load cpu_data with the memory output, set cpu_wait_n=1 and go to RD_HOLD.
REQ-022 RD_HOLD SHALL keep cpu_data stable until cpu_cs or cpu_rd deasserts, then return to RUN; a new read requires a strobe deassertion first.
REQ-023 Outside RD_WAIT, cpu_wait_n SHALL be 1 unless REQ-019 or REQ-020 applies.
REQ-024 In any state, ld_start=1 SHALL force LOAD: ld_cnt=0, ld_done=0, any read in progress aborted, cpu_data unchanged.
REQ-025 When ld_start and ld_valid are high in the same cycle, ld_start SHALL win and the byte is not written.
REQ-026 In RUN/RD_*: ld_ready=0 and ld_valid SHALL be ignored.
REQ-027 cpu_addr SHALL be sampled only at read launch; address changes during RD_WAIT have no effect.
REQ-028 The CPU SHALL have no write path to the image.

Reset
REQ-029 rst_n=0 SHALL asynchronously set cpu_data=0, cpu_wait_n=1, ld_cnt=0 and the wait counter to 0.
REQ-030 Reset SHALL set the state to LOAD (ld_done=0, ld_ready=1) unless REQ-032 applies.
REQ-031 Memory contents SHALL NOT be affected by reset.

Configuration
REQ-032 With BOOTROM_INIT_EN defined:
- Memory is initialised at configuration with the default test image at 0x000-0x009: 21 00 D0 3E 00 77 23 3C 18 FB, all other locations 00.
- Reset enters RUN with ld_done=1.
- ld_start still permits overwrite.
REQ-033 Without BOOTROM_INIT_EN: memory has no initial contents, and the only way to populate it is download.

Structure
REQ-034 Package bootrom_pkg SHALL hold:
- the state enum;
- the default image byte constants;
- the WAIT_CYC counter width constant (3).
REQ-035 Storage SHALL be sub-module bootrom_mem: a single-clock RAM with one write port, one registered read port, and one-cycle read latency; the FSM and counters stay in bootrom_ldr.

Verification
REQ-036 Reset release without BOOTROM_INIT_EN, stream 2048 bytes (value = addr[7:0]), one every cycle -> ld_done=1 exactly one cycle after the last write; read 0x7FF returns FF.
REQ-037 WAIT_CYC=3, read 0x123 in RUN -> cpu_wait_n low for 4 cycles from strobe, then cpu_data=23; data holds until cs drops.
REQ-038 Read strobe during LOAD -> cpu_wait_n held low until ld_done, then the read completes with the correct byte.
REQ-039 ld_start during RD_WAIT with ld_valid=1 -> read aborted, cpu_wait_n=1, ld_cnt=0, byte discarded, location 0 unchanged.
REQ-040 With BOOTROM_INIT_EN, reset then read 0x000..0x009 -> 21 00 D0 3E 00 77 23 3C 18 FB, ld_done=1 from reset.
REQ-041 rst_n asserted mid-download at ld_cnt=0x400 -> immediate LOAD, ld_cnt=0; reload from 0 succeeds.
